// File: rtl/uart_pkg.sv
// Shared UART definitions: default frame and baud constants used by the rx/tx
// blocks, and the state encoding of the packet-level TX arbiter.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_BAUD_DIV  = 434;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } uart_arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bundle between the requesters, the arbiter and the shared UART
// transmitter. The arbiter takes the slave view; requesters plus transmitter
// take the master view.
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = UART_DATA_BITS
);

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*DATA_BITS-1:0] req_data;
  logic [NUM_REQ-1:0]           req_last;
  logic [NUM_REQ-1:0]           req_ready;
  logic                         tx_start;
  logic [DATA_BITS-1:0]         tx_data;
  logic                         tx_busy;

  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, tx_start, tx_data
  );

  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, tx_start, tx_data
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the search starts just after ptr and wraps
// modulo NUM_REQ. Usable by any arbiter that keeps its own pointer.
module rr_pick #(
  parameter int  NUM_REQ = 4,
  localparam int W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [W-1:0]       ptr,
  output logic [W-1:0]       idx,
  output logic               any
);

  // Walk the positions ptr+1 .. ptr+NUM_REQ in circular order; first hit wins.
  always_comb begin
    logic [W-1:0] cand;
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = W'((int'(ptr) + i) % NUM_REQ);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART transmitter among NUM_REQ
// byte-stream requesters. A granted requester owns the line until req_last.
// Optional build macro UART_ARB_GAP_EN inserts GAP_CYCLES idle cycles after
// each packet so the receiver can resynchronise.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int  NUM_REQ    = 4,
  parameter int  DATA_BITS  = UART_DATA_BITS,
  parameter int  GAP_CYCLES = 434,
  localparam int GW         = $clog2(NUM_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_tx_arbiter_if.slave bus,
  output logic [GW-1:0]    grant_id,
  output logic             grant_active
);

  if (NUM_REQ < 2) begin : g_bad_num_req
    $error("uart_tx_arbiter: NUM_REQ must be at least 2");
  end
  if (GAP_CYCLES < 1) begin : g_bad_gap
    $error("uart_tx_arbiter: GAP_CYCLES must be at least 1");
  end

  uart_arb_state_t      state_q, state_d;
  logic [GW-1:0]        ptr_q, ptr_d, grant_id_d, pick_idx;
  logic                 pick_any, grant_active_d;
  logic                 last_q, last_d;
  logic                 tx_start_q, tx_start_d;
  logic [DATA_BITS-1:0] tx_data_q, tx_data_d, sel_data;
  logic                 sel_valid, sel_last;
  logic [NUM_REQ-1:0]   grant_onehot, req_ready;

`ifdef UART_ARB_GAP_EN
  localparam int CW = $clog2(GAP_CYCLES + 1);
  logic [CW-1:0] gap_cnt_q, gap_cnt_d;
`endif

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req (bus.req_valid),
    .ptr (ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Route the granted requester's valid, last and byte onto a single lane.
  always_comb begin
    sel_valid    = 1'b0;
    sel_last     = 1'b0;
    sel_data     = '0;
    grant_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == GW'(i)) begin
        sel_valid       = bus.req_valid[i];
        sel_last        = bus.req_last[i];
        sel_data        = bus.req_data[i*DATA_BITS +: DATA_BITS];
        grant_onehot[i] = 1'b1;
      end
    end
  end

  // Next-state and next-register values; the grant is held until the packet's last byte finishes.
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    grant_id_d     = grant_id;
    grant_active_d = grant_active;
    last_d         = last_q;
    tx_data_d      = tx_data_q;
    tx_start_d     = 1'b0;
    req_ready      = '0;
`ifdef UART_ARB_GAP_EN
    gap_cnt_d      = gap_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_id_d     = pick_idx;
          grant_active_d = 1'b1;
          state_d        = ISSUE;
        end
      end
      ISSUE: begin
        // Only the granted lane can handshake; others wait for the next packet.
        if (sel_valid && !bus.tx_busy) begin
          req_ready  = grant_onehot;
          tx_data_d  = sel_data;
          last_d     = sel_last;
          tx_start_d = 1'b1;
          state_d    = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (bus.tx_busy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          if (last_q) begin
            ptr_d          = grant_id;
            grant_active_d = 1'b0;
`ifdef UART_ARB_GAP_EN
            state_d        = GAP;
`else
            state_d        = IDLE;
`endif
          end else begin
            state_d = ISSUE;
          end
        end
      end
`ifdef UART_ARB_GAP_EN
      GAP: begin
        if (gap_cnt_q == CW'(GAP_CYCLES - 1)) begin
          gap_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + CW'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any packet in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= GW'(NUM_REQ - 1);
      grant_id     <= '0;
      grant_active <= 1'b0;
      last_q       <= 1'b0;
      tx_data_q    <= '0;
      tx_start_q   <= 1'b0;
`ifdef UART_ARB_GAP_EN
      gap_cnt_q    <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      grant_id     <= grant_id_d;
      grant_active <= grant_active_d;
      last_q       <= last_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
`ifdef UART_ARB_GAP_EN
      gap_cnt_q    <= gap_cnt_d;
`endif
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.tx_start  = tx_start_q;
  assign bus.tx_data   = tx_data_q;

endmodule
